// File: rtl/dtpu_pkg.sv
// Shared types and constants for the DTPU load path: packer FSM states and
// the element-per-word helper.
package dtpu_pkg;

    localparam int DTPU_DATA_WIDTH = 64;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } pack_state_t;

    function automatic int elems_per_word(input int data_width, input int elem_width);
        return data_width / elem_width;
    endfunction

endpackage

// File: rtl/dtpu_sync_fifo.sv
// First-word fall-through synchronous FIFO. Pointers carry one extra wrap bit
// so full and empty can be told apart without a separate occupancy counter.
module dtpu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    // A pop in the same cycle never opens room for a push into a full FIFO.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/dtpu_load_packer.sv
// Packs a narrow element stream little-endian into DATA_WIDTH words and queues
// them for the load/store unit. Optional LOAD_PACKER_STATS_EN adds push counters.
module dtpu_load_packer
    import dtpu_pkg::*;
#(
    parameter int DATA_WIDTH = DTPU_DATA_WIDTH,
    parameter int ELEM_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ELEM_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [$clog2(DATA_WIDTH/ELEM_WIDTH):0] m_count,
    output logic                  m_last
`ifdef LOAD_PACKER_STATS_EN
    ,
    output logic [31:0]           stat_words,
    output logic [31:0]           stat_partial
`endif
);
    localparam int ELEMS = elems_per_word(DATA_WIDTH, ELEM_WIDTH);
    localparam int CW    = $clog2(ELEMS) + 1;
    localparam int EW    = DATA_WIDTH + CW + 1;

    if ((DATA_WIDTH % ELEM_WIDTH) != 0 || (DATA_WIDTH / ELEM_WIDTH) < 2) begin : g_bad_width
        $error("dtpu_load_packer: DATA_WIDTH must be a multiple of ELEM_WIDTH with at least 2 elements");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dtpu_load_packer: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    pack_state_t           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] pack_q, pack_d;
    logic [CW-1:0]         hold_count_q, hold_count_d;
    logic                  hold_last_q, hold_last_d;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [EW-1:0]         fifo_din;
    logic [EW-1:0]         fifo_dout;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pack_d       = pack_q;
        hold_count_d = hold_count_q;
        hold_last_d  = hold_last_q;
        push         = 1'b0;
        s_ready      = 1'b1;
        case (state_q)
            ACCUM: begin
                if (s_valid) begin
                    for (int i = 0; i < ELEMS; i++) begin
                        if (cnt_q == CW'(i)) pack_d[i*ELEM_WIDTH +: ELEM_WIDTH] = s_data;
                    end
                    if (cnt_q == CW'(ELEMS - 1) || s_last) begin
                        state_d      = HOLD;
                        hold_count_d = cnt_q + CW'(1);
                        hold_last_d  = s_last;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                s_ready = !fifo_full;
                if (!fifo_full) begin
                    // Hand the finished word over and start the next one in the same cycle.
                    push    = 1'b1;
                    pack_d  = '0;
                    state_d = ACCUM;
                    cnt_d   = '0;
                    if (s_valid) begin
                        pack_d[ELEM_WIDTH-1:0] = s_data;
                        if (s_last) begin
                            state_d      = HOLD;
                            hold_count_d = CW'(1);
                            hold_last_d  = 1'b1;
                        end else begin
                            cnt_d = CW'(1);
                        end
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ACCUM;
            cnt_q        <= '0;
            pack_q       <= '0;
            hold_count_q <= '0;
            hold_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pack_q       <= pack_d;
            hold_count_q <= hold_count_d;
            hold_last_q  <= hold_last_d;
        end
    end

    assign fifo_din = {hold_last_q, hold_count_q, pack_q};

    dtpu_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (m_valid && m_ready),
        .din    (fifo_din),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Head fields read as zero while empty so the outputs are clean after reset.
    assign m_valid = !fifo_empty;
    assign {m_last, m_count, m_data} = fifo_empty ? '0 : fifo_dout;

`ifdef LOAD_PACKER_STATS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_words   <= '0;
            stat_partial <= '0;
        end else if (push) begin
            stat_words <= stat_words + 32'd1;
            if (hold_count_q != CW'(ELEMS)) stat_partial <= stat_partial + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dtpu_load_packer.sv
// Randomized self-checking bench for dtpu_load_packer against a queue-based
// packing model; the stats scenario runs when LOAD_PACKER_STATS_EN is defined.
module tb_dtpu_load_packer;
    localparam int DW    = 64;
    localparam int EWD   = 8;
    localparam int ELEMS = DW / EWD;
    localparam int CW    = $clog2(ELEMS) + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            count;
        logic          last;
    } word_t;

    logic           clk;
    logic           resetn;
    logic           s_valid;
    logic           s_ready;
    logic [EWD-1:0] s_data;
    logic           s_last;
    logic           m_valid;
    logic           m_ready;
    logic [DW-1:0]  m_data;
    logic [CW-1:0]  m_count;
    logic           m_last;
`ifdef LOAD_PACKER_STATS_EN
    logic [31:0]    stat_words;
    logic [31:0]    stat_partial;
`endif

    dtpu_load_packer #(
        .DATA_WIDTH (DW),
        .ELEM_WIDTH (EWD),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_count (m_count),
        .m_last  (m_last)
`ifdef LOAD_PACKER_STATS_EN
        ,
        .stat_words   (stat_words),
        .stat_partial (stat_partial)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    nvec = 0;
    int    nerr = 0;
    int    popped = 0;
    word_t expq[$];
    logic [EWD-1:0] part[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: collect accepted elements, close a word at ELEMS or s_last,
    // and compare each popped head word against the oldest closed word.
    always @(negedge clk) begin
        if (!resetn) begin
            expq.delete();
            part.delete();
        end else begin
            if (m_valid && m_ready) begin
                popped++;
                if (expq.size() == 0) begin
                    check("spurious_word", 64'd1, 64'd0);
                end else begin
                    word_t w;
                    w = expq.pop_front();
                    check("word_data", m_data, w.data);
                    check("word_count", 64'(m_count), 64'(w.count));
                    check("word_last", 64'(m_last), 64'(w.last));
                end
            end
            if (s_valid && s_ready) begin
                part.push_back(s_data);
                if (part.size() == ELEMS || s_last) begin
                    word_t w;
                    w.data = '0;
                    for (int i = 0; i < part.size(); i++) w.data |= 64'(part[i]) << (EWD * i);
                    w.count = part.size();
                    w.last  = s_last;
                    expq.push_back(w);
                    part.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [EWD-1:0] d, input logic l);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!ok && n < 500) begin
            @(negedge clk);
            ok = s_ready;
            tick();
            n++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!ok) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_ready = 1'b1;
        while ((expq.size() != 0 || m_valid) && n < 300) begin
            tick();
            n++;
        end
        check("drain_queue_empty", 64'(expq.size()), 64'd0);
    endtask

    bit rand_rdy = 1'b0;

    initial begin
        int p0;
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;

        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", m_data, 64'd0);
        check("rst_m_count", 64'(m_count), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);

        // Full word, back-to-back, with latency check
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(EWD'(i), 1'b0);
        check("s1_latency1_m_valid", 64'(m_valid), 64'd0);
        tick();
        check("s1_m_valid", 64'(m_valid), 64'd1);
        check("s1_m_data", m_data, 64'h0807060504030201);
        check("s1_m_count", 64'(m_count), 64'd8);
        check("s1_m_last", 64'(m_last), 64'd0);

        // Partial word closed by s_last
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        tick();
        check("s2_m_valid", 64'(m_valid), 64'd1);
        check("s2_m_data", m_data, 64'h0000000000CCBBAA);
        check("s2_m_count", 64'(m_count), 64'd3);
        check("s2_m_last", 64'(m_last), 64'd1);
        drain();

        // Backpressure: fill FIFO, hold a fifth word, then stall
        m_ready = 1'b0;
        p0 = popped;
        for (int i = 0; i < 40; i++) send(EWD'(i), 1'b0);
        s_valid = 1'b1;
        s_data  = 8'd40;
        tick();
        @(negedge clk);
        check("s3_stall_s_ready", 64'(s_ready), 64'd0);
        check("s3_head_m_valid", 64'(m_valid), 64'd1);
        check("s3_head_m_data", m_data, 64'h0706050403020100);
        tick();
        m_ready = 1'b1;
        for (int i = 40; i < 48; i++) send(EWD'(i), 1'b0);
        drain();
        check("s3_words_out", 64'(popped - p0), 64'd6);

        // Random traffic with random consumer backpressure
        rand_rdy = 1'b1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) tick();
                    send(EWD'($urandom), (i == 999) ? 1'b1 : ($urandom_range(0, 5) == 0));
                end
                rand_rdy = 1'b0;
            end
            begin
                while (rand_rdy) begin
                    m_ready = ($urandom_range(0, 2) != 0);
                    tick();
                end
            end
        join
        drain();

        // Reset with a partial word pending and two words queued
        m_ready = 1'b0;
        for (int i = 0; i < 21; i++) send(EWD'($urandom), 1'b0);
        check("s5_pre_m_valid", 64'(m_valid), 64'd1);
        do_reset();
        check("s5_m_valid", 64'(m_valid), 64'd0);
        check("s5_s_ready", 64'(s_ready), 64'd1);
        m_ready = 1'b1;
        p0 = popped;
        for (int i = 0; i < 8; i++) send(EWD'(8'h10 + i), 1'b0);
        tick();
        check("s5_clean_m_data", m_data, 64'h1716151413121110);
        check("s5_clean_m_count", 64'(m_count), 64'd8);
        drain();
        check("s5_words_out", 64'(popped - p0), 64'd1);

`ifdef LOAD_PACKER_STATS_EN
        do_reset();
        check("s6_stat_words_rst", 64'(stat_words), 64'd0);
        m_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            send(8'hAA, 1'b0);
            send(8'hBB, 1'b0);
            send(8'hCC, 1'b1);
        end
        for (int i = 1; i <= 8; i++) send(EWD'(i), 1'b0);
        drain();
        check("s6_stat_words", 64'(stat_words), 64'd3);
        check("s6_stat_partial", 64'(stat_partial), 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
